// File: rtl/uart_packet_scheduler.sv
// Byte FIFO plus framing sequencer feeding the BPSK modulator: preamble, sync, length, payload, checksum.
// Build option PKT_SCHED_CRC_EN selects a CRC-8 (poly 0x07) checksum instead of the default XOR.
module uart_packet_scheduler #(
  parameter int          FIFO_DEPTH     = 16,
  parameter int          PKT_LEN        = 8,
  parameter int          PREAMBLE_BYTES = 2,
  parameter logic [7:0]  SYNC_WORD      = 8'hD3,
  parameter int          FLUSH_TIMEOUT  = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    uart_word,
  input  logic                          uart_ready,
  output logic                          tx_bit,
  output logic                          tx_valid,
  input  logic                          tx_accept,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SYNC,
    S_LEN,
    S_PAY,
    S_CSUM
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     byte_cnt_q, byte_cnt_d;
  logic [7:0]     len_q, len_d;
  logic [7:0]     csum_q, csum_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           ready_q;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           overflow_q, overflow_d;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [7:0]     head;
  logic           push_req, push, pop, launch, accept;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] data);
    logic [7:0] c;
`ifdef PKT_SCHED_CRC_EN
    c = acc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
`else
    c = acc ^ data;
`endif
    return c;
  endfunction

  // Rising edge of the level-style ready strobe gives exactly one push per pulse.
  always_comb begin
    push_req   = uart_ready && !ready_q;
    push       = push_req && (count_q != CW'(FIFO_DEPTH));
    overflow_d = overflow_q || (push_req && (count_q == CW'(FIFO_DEPTH)));
    head       = mem[rd_ptr_q];
    accept     = (state_q != S_IDLE) && tx_accept;
    launch     = (state_q == S_IDLE) &&
                 ((count_q >= CW'(PKT_LEN)) ||
                  ((timer_q == TW'(FLUSH_TIMEOUT)) && (count_q != '0)));
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    csum_d     = csum_q;
    pop        = 1'b0;

    if (state_q == S_IDLE) begin
      if (launch) begin
        state_d    = S_PRE;
        shreg_d    = 8'hAA;
        bit_cnt_d  = 3'd0;
        byte_cnt_d = 8'd0;
        csum_d     = 8'd0;
        len_d      = (count_q >= CW'(PKT_LEN)) ? 8'(PKT_LEN) : 8'(count_q);
      end
    end else if (accept) begin
      if (bit_cnt_q != 3'd7) begin
        shreg_d   = {shreg_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end else begin
        // Byte boundary: load the next byte directly so there is no bubble.
        bit_cnt_d = 3'd0;
        case (state_q)
          S_PRE: begin
            if (byte_cnt_q == 8'(PREAMBLE_BYTES - 1)) begin
              state_d = S_SYNC;
              shreg_d = SYNC_WORD;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
              shreg_d    = 8'hAA;
            end
          end
          S_SYNC: begin
            state_d = S_LEN;
            shreg_d = len_q;
          end
          S_LEN: begin
            state_d    = S_PAY;
            shreg_d    = head;
            pop        = 1'b1;
            byte_cnt_d = 8'd0;
            csum_d     = csum_step(csum_q, head);
          end
          S_PAY: begin
            if (byte_cnt_q == len_q - 8'd1) begin
              state_d = S_CSUM;
              shreg_d = csum_q;
            end else begin
              shreg_d    = head;
              pop        = 1'b1;
              byte_cnt_d = byte_cnt_q + 8'd1;
              csum_d     = csum_step(csum_q, head);
            end
          end
          default: begin
            state_d = S_IDLE;
            shreg_d = 8'd0;
          end
        endcase
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    timer_d = timer_q;
    if (launch || (count_q == '0)) timer_d = '0;
    else if ((state_q == S_IDLE) && (count_q < CW'(PKT_LEN)) && (timer_q != TW'(FLUSH_TIMEOUT)))
      timer_d = timer_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shreg_q    <= 8'd0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 8'd0;
      len_q      <= 8'd0;
      csum_q     <= 8'd0;
      timer_q    <= '0;
      ready_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      timer_q    <= timer_d;
      ready_q    <= uart_ready;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset so it can map onto RAM; the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= uart_word;
  end

  assign tx_bit     = shreg_q[7];
  assign tx_valid   = (state_q != S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_packet_scheduler.sv
// Randomized self-checking bench for uart_packet_scheduler; packets are predicted from a byte-queue model.
// Define PKT_SCHED_CRC_EN for both bench and RTL to exercise the CRC-8 build.
module tb_uart_packet_scheduler;

  localparam int          FIFO_DEPTH     = 16;
  localparam int          PKT_LEN        = 8;
  localparam int          PREAMBLE_BYTES = 2;
  localparam logic [7:0]  SYNC_WORD      = 8'hD3;
  localparam int          FLUSH_TIMEOUT  = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] uart_word = 8'd0;
  logic       uart_ready = 1'b0;
  logic       tx_accept = 1'b0;
  logic       tx_bit, tx_valid, busy, overflow;
  logic [4:0] fifo_count;

  uart_packet_scheduler #(
    .FIFO_DEPTH(FIFO_DEPTH), .PKT_LEN(PKT_LEN), .PREAMBLE_BYTES(PREAMBLE_BYTES),
    .SYNC_WORD(SYNC_WORD), .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_word(uart_word), .uart_ready(uart_ready),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_accept(tx_accept), .busy(busy),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned busy_cyc = 0;
  bit          got[$];
  logic [7:0]  mq[$];
  logic [7:0]  exp_q[$];
  bit          rand_acc = 1'b0;
  logic        prev_valid = 1'b0, prev_accept = 1'b0, prev_bit = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Accepted-bit collector plus hold-stability check while the modulator stalls.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_valid && !prev_accept) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_bit", tx_bit, prev_bit);
      end
      if (tx_valid && tx_accept) got.push_back(tx_bit);
      if (busy) busy_cyc++;
    end
    prev_valid  = tx_valid && rst_n;
    prev_accept = tx_accept;
    prev_bit    = tx_bit;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got=expired exp=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_csum(input logic [7:0] acc, input logic [7:0] b);
    logic [7:0] c;
    logic       fb;
`ifdef PKT_SCHED_CRC_EN
    c = acc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ b[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
`else
    fb = 1'b0;
    c  = acc ^ b;
`endif
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_acc) tx_accept = 1'($urandom_range(0, 1));
  endtask

  task automatic push_byte(input logic [7:0] b, input int hi, output int unsigned t_raise);
    uart_word  = b;
    uart_ready = 1'b1;
    t_raise    = cyc;
    if (mq.size() < FIFO_DEPTH) mq.push_back(b);
    repeat (hi) tick();
    uart_ready = 1'b0;
    repeat (2) tick();
  endtask

  // Packet expected from the model queue: length is min(buffered, PKT_LEN).
  task automatic build_expected();
    int         n;
    logic [7:0] cs, b;
    exp_q.delete();
    n = (mq.size() >= PKT_LEN) ? PKT_LEN : mq.size();
    for (int i = 0; i < PREAMBLE_BYTES; i++) exp_q.push_back(8'hAA);
    exp_q.push_back(SYNC_WORD);
    exp_q.push_back(8'(n));
    cs = 8'd0;
    for (int i = 0; i < n; i++) begin
      b  = mq.pop_front();
      cs = model_csum(cs, b);
      exp_q.push_back(b);
    end
    exp_q.push_back(cs);
  endtask

  task automatic check_packet(input string name);
    int         need;
    logic [7:0] v;
    build_expected();
    need = exp_q.size() * 8;
    for (int i = 0; i < 3000 && got.size() < need; i++) tick();
    if (got.size() < need) begin
      chk({name, "_bits"}, got.size(), need);
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        v = 8'd0;
        for (int j = 0; j < 8; j++) v = {v[6:0], 1'(got.pop_front())};
        chk($sformatf("%s_byte%0d", name, k), v, exp_q[k]);
      end
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000 && busy; i++) tick();
    chk({name, "_idle"}, busy, 0);
  endtask

  initial begin
    int unsigned t0, td, b0;
    logic [7:0]  b;

    tx_accept = 1'b1;
    repeat (3) tick();
    chk("rst_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bit", tx_bit, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    tick();

    // Full packet of 0x01..0x08 with the modulator always ready.
    got.delete();
    b0 = busy_cyc;
    for (int i = 1; i <= 8; i++) push_byte(8'(i), 2, td);
    check_packet("full");
    wait_idle("full");
    chk("full_busy_cycles", busy_cyc - b0, 104);
    chk("full_count", fifo_count, 0);

    // Partial packet with long ready pulses, launched by the flush timeout.
    got.delete();
    push_byte(8'h10, 40, t0);
    chk("long_pulse_count1", fifo_count, 1);
    push_byte(8'h20, 40, td);
    chk("long_pulse_count2", fifo_count, 2);
    push_byte(8'h30, 40, td);
    chk("long_pulse_count3", fifo_count, 3);
    chk("timeout_not_early", tx_valid, 0);
    while (!tx_valid && (cyc - t0) < FLUSH_TIMEOUT + 100) tick();
    chk("timeout_launch_delay", cyc - t0, FLUSH_TIMEOUT + 2);
    check_packet("timeout");
    wait_idle("timeout");

    // Overflow with the modulator stalled from launch, then two back-to-back packets.
    got.delete();
    tx_accept = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'($urandom), 2, td);
    chk("ovf_count_full", fifo_count, 16);
    chk("ovf_before", overflow, 0);
    chk("ovf_launched", tx_valid, 1);
    push_byte(8'($urandom), 2, td);
    chk("ovf_count_after", fifo_count, 16);
    chk("ovf_after", overflow, 1);
    tx_accept = 1'b1;
    check_packet("ovf_pkt1");
    check_packet("ovf_pkt2");
    wait_idle("ovf");
    chk("ovf_drain_count", fifo_count, 0);
    chk("ovf_sticky", overflow, 1);

    // Random modulator back-pressure must not alter the bit stream.
    got.delete();
    rand_acc = 1'b1;
    for (int i = 1; i <= 8; i++) push_byte(8'(i), 2, td);
    check_packet("rand_acc");
    rand_acc  = 1'b0;
    tx_accept = 1'b1;
    wait_idle("rand_acc");

    // Reset during the fourth payload byte, then a clean packet.
    got.delete();
    for (int i = 0; i < 8; i++) push_byte(8'($urandom), 2, td);
    for (int i = 0; i < 3000 && got.size() < (PREAMBLE_BYTES + 2 + 3) * 8 + 3; i++) tick();
    chk("mid_reached", tx_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_ovf", overflow, 0);
    tick();
    tick();
    rst_n = 1'b1;
    mq.delete();
    got.delete();
    tick();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      push_byte(b, 2, td);
    end
    check_packet("post_rst");
    wait_idle("post_rst");
    chk("post_rst_count", fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_packet_scheduler.md
Name: uart_packet_scheduler

Overview:
- Sits between the UART deserializer and the BPSK bit modulator in the transmitter.
- Captures deserialized bytes into a FIFO and decides when a packet is launched.
- Sequences the bit stream sent to the modulator: preamble, sync, length, payload, checksum.
- Launch condition: a full packet's worth of bytes is buffered, or a timeout expires on a partial packet.

Parameters:
- FIFO_DEPTH, 16, byte FIFO entries (power of 2, ≥ PKT_LEN)
- PKT_LEN, 8, max payload bytes per packet (1..255)
- PREAMBLE_BYTES, 2, count of 8'hAA bytes sent before sync
- SYNC_WORD, 8'hD3, frame sync byte
- FLUSH_TIMEOUT, 4096, clk cycles a partial packet waits before forced launch

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- uart_word  in  8  byte from deserializer; valid while uart_ready high
- uart_ready  in  1  level from deserializer (held high multiple clk cycles); already synchronized to clk
- tx_bit  out  1  current bit to modulator
- tx_valid  out  1  tx_bit valid
- tx_accept  in  1  modulator consumes tx_bit on clk edge where tx_valid && tx_accept
- busy  out  1  high from packet launch until last checksum bit accepted
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered
- overflow  out  1  sticky; set when a byte arrives with FIFO full

Behaviour:
- Reset (async, rst_n low): state IDLE; FIFO empty; timeout counter 0; tx_bit 0; tx_valid 0; busy 0; overflow 0; fifo_count 0.
- Capture:
  - Rising edge of uart_ready (registered previous value) pushes uart_word once per pulse.
  - Pulse width does not matter.
  - FIFO full on push: byte dropped; overflow set (cleared only by reset).
- Timeout counter:
  - Counts while IDLE and 0 < fifo_count < PKT_LEN.
  - Clears on launch or when fifo_count reaches 0.
  - Saturates at FLUSH_TIMEOUT.
- Launch from IDLE, checked every cycle:
  - fifo_count ≥ PKT_LEN: len = PKT_LEN.
  - Else if timeout counter == FLUSH_TIMEOUT and fifo_count > 0: len = fifo_count.
  - len is latched at launch; pushes during a packet do not change it.
- States:
  - IDLE → PREAMBLE → SYNC → LEN → PAYLOAD → CSUM → IDLE.
  - Each state shifts whole bytes MSB first; 8 accepted bits per byte.
  - PREAMBLE repeats 8'hAA PREAMBLE_BYTES times.
  - LEN sends len.
  - PAYLOAD pops one FIFO byte per byte slot; the pop happens when the byte is loaded into the shift register, len bytes total.
  - CSUM sends XOR of all payload bytes.
- Handshake:
  - tx_valid is high in every non-IDLE state.
  - tx_bit changes only after an accept.
  - With tx_accept held high, one bit per clk and no bubbles between bytes or states.
  - The first bit (preamble MSB) is presented the cycle after the launch decision.
- busy:
  - Rises with tx_valid.
  - Falls the cycle after the final CSUM bit is accepted; tx_valid falls the same cycle.
  - A back-to-back launch may occur in that IDLE cycle, giving one idle cycle minimum between packets.
- Simultaneous push and pop: both occur; fifo_count unchanged.
- tx_accept low: all outputs hold; no timeout counting (not IDLE).
- Reset mid-packet: packet abandoned; tx_valid drops immediately; FIFO contents discarded.

Optional Feature:
- Macro: PKT_SCHED_CRC_EN.
- Defined: CSUM byte is CRC-8, poly 0x07, init 0x00, no reflection, no final XOR, computed over payload bytes MSB first.
- Undefined: CSUM is XOR of payload bytes.
- Packet length and timing are identical in both builds.

Test Plan:
- Reset, then push 8 bytes 0x01..0x08, tx_accept=1:
  - Stream: AA AA D3 08 01..08 then checksum 0x08, 104 bits on consecutive cycles.
  - busy high for exactly 104 cycles.
  - fifo_count returns to 0.
- Push 3 bytes 0x10 0x20 0x30 and wait:
  - No launch before FLUSH_TIMEOUT cycles.
  - Then LEN=0x03, payload 10 20 30, checksum 0x00.
  - With CRC_EN, checksum is the CRC-8 of those bytes, checked against the reference model.
- Push 17 bytes with tx_accept=0 held from launch:
  - 17th byte dropped; overflow=1.
  - fifo_count=16 before the first pop.
- Drive tx_accept with random 50% toggling:
  - Bit sequence identical to the first scenario.
  - tx_bit stable whenever tx_accept=0.
- Hold uart_ready high 40 cycles per byte: exactly one push per pulse.
- Assert rst_n low during PAYLOAD byte 4:
  - tx_valid=0, busy=0, fifo_count=0 immediately.
  - Next packet starts cleanly with preamble.
